// File: rtl/avalon_cmd_master.sv
// Single-outstanding Avalon-MM master: one valid/ready command in,
// one Avalon transfer out, one response back (data, ack or timeout).
module avalon_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Cmd_Valid,
   output logic        o_Cmd_Ready,
   input  logic        i_Cmd_Write,
   input  logic [29:0] i_Cmd_Addr,
   input  logic [3:0]  i_Cmd_ByteEn,
   input  logic [31:0] i_Cmd_WriteData,
   output logic        o_Rsp_Valid,
   input  logic        i_Rsp_Ready,
   output logic        o_Rsp_Write,
   output logic        o_Rsp_Error,
   output logic [31:0] o_Rsp_ReadData,
   output logic [29:0] o_AV_Addr,
   output logic [3:0]  o_AV_ByteEn,
   output logic        o_AV_Read,
   input  logic [31:0] i_AV_ReadData,
   output logic        o_AV_Write,
   output logic [31:0] o_AV_WriteData,
   input  logic        i_AV_WaitRequest
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TMAX =
      (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CNT_MAX = CW'(TMAX);
   localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          wr_q;
   logic [29:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          rd_q;
   logic          wstb_q;
   logic          rsp_valid_q;
   logic          rsp_write_q;
   logic          rsp_error_q;
   logic [31:0]   rsp_rdata_q;

   // Ready is gated by reset so it drops without waiting for an edge.
   assign o_Cmd_Ready    = (state_q == IDLE) && !i_Rst;
   assign o_AV_Addr      = addr_q;
   assign o_AV_ByteEn    = be_q;
   assign o_AV_WriteData = wdata_q;
   assign o_AV_Read      = rd_q;
   assign o_AV_Write     = wstb_q;
   assign o_Rsp_Valid    = rsp_valid_q;
   assign o_Rsp_Write    = rsp_write_q;
   assign o_Rsp_Error    = rsp_error_q;
   assign o_Rsp_ReadData = rsp_rdata_q;

   // Command FSM: accept, hold the strobe through waitrequest, respond.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         wstb_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_Cmd_Valid) begin
                  addr_q  <= i_Cmd_Addr;
                  be_q    <= i_Cmd_ByteEn;
                  wdata_q <= i_Cmd_WriteData;
                  wr_q    <= i_Cmd_Write;
                  rd_q    <= !i_Cmd_Write;
                  wstb_q  <= i_Cmd_Write;
                  cnt_q   <= '0;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!i_AV_WaitRequest) begin
                  rd_q        <= 1'b0;
                  wstb_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b0;
                  rsp_write_q <= wr_q;
                  rsp_rdata_q <= wr_q ? 32'h0 : i_AV_ReadData;
                  state_q     <= RESP;
               end else if (TO_EN && (cnt_q == CNT_MAX)) begin
                  rd_q        <= 1'b0;
                  wstb_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b1;
                  rsp_write_q <= wr_q;
                  rsp_rdata_q <= 32'h0;
                  state_q     <= RESP;
               end else if (TO_EN) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RESP: begin
               if (i_Rsp_Ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Directed bench for avalon_cmd_master with TIMEOUT_CYCLES=8.
// The bench plays the Avalon slave and the response consumer.
module tb_avalon_cmd_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [29:0] cmd_addr = '0;
   logic [3:0]  cmd_be = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic [29:0] av_addr;
   logic [3:0]  av_be;
   logic        av_read;
   logic [31:0] av_rdata_w;
   logic        av_write;
   logic [31:0] av_wdata;
   logic        av_wait = 1'b1;
   logic [31:0] av_rdata = '0;
   logic        auto_rd = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   assign av_rdata_w = auto_rd ? (32'hA000_0000 | {2'b00, av_addr})
                               : av_rdata;

   avalon_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
      .i_Clk            (clk),
      .i_Rst            (rst),
      .i_Cmd_Valid      (cmd_valid),
      .o_Cmd_Ready      (cmd_ready),
      .i_Cmd_Write      (cmd_write),
      .i_Cmd_Addr       (cmd_addr),
      .i_Cmd_ByteEn     (cmd_be),
      .i_Cmd_WriteData  (cmd_wdata),
      .o_Rsp_Valid      (rsp_valid),
      .i_Rsp_Ready      (rsp_ready),
      .o_Rsp_Write      (rsp_write),
      .o_Rsp_Error      (rsp_error),
      .o_Rsp_ReadData   (rsp_rdata),
      .o_AV_Addr        (av_addr),
      .o_AV_ByteEn      (av_be),
      .o_AV_Read        (av_read),
      .i_AV_ReadData    (av_rdata_w),
      .o_AV_Write       (av_write),
      .o_AV_WriteData   (av_wdata),
      .i_AV_WaitRequest (av_wait)
   );

   always #5 clk = ~clk;

   // Read and write strobes must never overlap.
   always @(negedge clk) begin
      n_cmp++;
      if (av_read && av_write) begin
         n_err++;
         $display("FAIL strobe_overlap: read=%b write=%b required not both",
                  av_read, av_write);
      end
   end

   // Present one command, play a slave that stalls `stalls` cycles,
   // and report how long the strobe stayed high and whether the bus
   // stayed stable. Returns at the negedge after the strobe falls.
   task automatic run_cmd(input logic wr, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int stalls, input logic [31:0] rd,
                          output int hi, output logic stable);
      int w;
      hi = 0;
      stable = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_be    = be;
      cmd_wdata = wd;
      av_wait   = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!(av_read || av_write)) break;
         hi++;
         if (av_addr !== a || av_be !== be || av_write !== wr ||
             av_read !== !wr || (wr && av_wdata !== wd))
            stable = 1'b0;
         av_wait  = (k < stalls);
         av_rdata = (k == stalls) ? rd : 32'hDEAD_BEEF;
         @(posedge clk);
      end
      av_wait = 1'b1;
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      #13;
      v = {cmd_ready, rsp_valid, rsp_write, rsp_error,
           av_read, av_write, av_be, 22'h0};
      n_cmp++;
      if (v !== 32'h0 || rsp_rdata !== 32'h0 || av_addr !== 30'h0 ||
          av_wdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: flags=%h rdata=%h addr=%h wdata=%h required 0",
                  v, rsp_rdata, av_addr, av_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_write_stall();
      int hi;
      logic st;
      run_cmd(1'b1, 30'h0, 4'hF, 32'h5A5A_5A5A, 5, 32'h0, hi, st);
      n_cmp++;
      if (hi !== 6) begin
         n_err++;
         $display("FAIL wr_strobe_len: got %0d required 6", hi);
      end
      n_cmp++;
      if (st !== 1'b1) begin
         n_err++;
         $display("FAIL wr_bus_stable: got %b required 1", st);
      end
      n_cmp++;
      if ({rsp_valid, rsp_write, rsp_error, cmd_ready} !== 4'b1100) begin
         n_err++;
         $display("FAIL wr_rsp: v/w/e/rdy got %b%b%b%b required 1100",
                  rsp_valid, rsp_write, rsp_error, cmd_ready);
      end
      ack_rsp();
   endtask

   task automatic test_read_stall();
      int hi;
      logic st;
      run_cmd(1'b0, 30'h3FFF_FFFF, 4'hF, 32'h0, 4, 32'h1234_5678, hi, st);
      n_cmp++;
      if (hi !== 5) begin
         n_err++;
         $display("FAIL rd_strobe_len: got %0d required 5", hi);
      end
      n_cmp++;
      if (st !== 1'b1) begin
         n_err++;
         $display("FAIL rd_bus_stable: got %b required 1", st);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_error !== 1'b0 ||
          rsp_rdata !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL rd_rsp: v=%b w=%b e=%b d=%h required 1 0 0 12345678",
                  rsp_valid, rsp_write, rsp_error, rsp_rdata);
      end
      ack_rsp();
      @(negedge clk);
      n_cmp++;
      if (av_addr !== 30'h3FFF_FFFF || av_read !== 1'b0) begin
         n_err++;
         $display("FAIL idle_bus_hold: addr=%h rd=%b required 3fffffff 0",
                  av_addr, av_read);
      end
   endtask

   task automatic test_back_to_back();
      logic [29:0] addrs [4];
      logic        wrs   [4];
      logic [31:0] exp_d [4];
      int idx, nrsp, last_acc, hi_tot, consec, gap_bad;
      logic hi, prev_hi, acc;
      addrs = '{30'd1, 30'd2, 30'd3, 30'd4};
      wrs   = '{1'b0, 1'b1, 1'b0, 1'b0};
      exp_d = '{32'hA000_0001, 32'h0, 32'hA000_0003, 32'hA000_0004};
      idx = 0; nrsp = 0; last_acc = -1;
      hi_tot = 0; consec = 0; gap_bad = 0; prev_hi = 1'b0;
      auto_rd = 1'b1;
      av_wait = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wrs[0];
      cmd_addr  = addrs[0];
      cmd_wdata = 32'h1111_0000;
      for (int c = 0; c < 40 && nrsp < 4; c++) begin
         hi = av_read | av_write;
         if (hi) hi_tot++;
         if (hi && prev_hi) consec++;
         prev_hi = hi;
         if (rsp_valid) begin
            n_cmp++;
            if (rsp_write !== wrs[nrsp] || rsp_rdata !== exp_d[nrsp] ||
                rsp_error !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_rsp%0d: w=%b d=%h e=%b required w=%b d=%h e=0",
                        nrsp, rsp_write, rsp_rdata, rsp_error,
                        wrs[nrsp], exp_d[nrsp]);
            end
            nrsp++;
         end
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            if (last_acc >= 0 && c - last_acc != 3) gap_bad++;
            last_acc = c;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               cmd_write = wrs[idx];
               cmd_addr  = addrs[idx];
               cmd_wdata = 32'h1111_0000 + idx;
            end else begin
               cmd_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      auto_rd = 1'b0;
      av_wait = 1'b1;
      cmd_valid = 1'b0;
      n_cmp++;
      if (nrsp !== 4 || idx !== 4) begin
         n_err++;
         $display("FAIL b2b_count: rsp=%0d acc=%0d required 4 4", nrsp, idx);
      end
      n_cmp++;
      if (hi_tot !== 4 || consec !== 0) begin
         n_err++;
         $display("FAIL b2b_strobe: cycles=%0d consec=%0d required 4 0",
                  hi_tot, consec);
      end
      n_cmp++;
      if (gap_bad !== 0) begin
         n_err++;
         $display("FAIL b2b_spacing: bad gaps=%0d required 0", gap_bad);
      end
   endtask

   task automatic test_timeout();
      int hi;
      logic st;
      run_cmd(1'b0, 30'h15, 4'h3, 32'h0, 100, 32'hFFFF_FFFF, hi, st);
      av_rdata = 32'hFFFF_FFFF;
      n_cmp++;
      if (hi !== 8) begin
         n_err++;
         $display("FAIL to_strobe_len: got %0d required 8", hi);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL to_rsp: v=%b e=%b d=%h required 1 1 0",
                  rsp_valid, rsp_error, rsp_rdata);
      end
      ack_rsp();
      run_cmd(1'b0, 30'h16, 4'hF, 32'h0, 7, 32'h8765_4321, hi, st);
      n_cmp++;
      if (hi !== 8) begin
         n_err++;
         $display("FAIL to_edge_len: got %0d required 8", hi);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 ||
          rsp_rdata !== 32'h8765_4321) begin
         n_err++;
         $display("FAIL to_edge_rsp: v=%b e=%b d=%h required 1 0 87654321",
                  rsp_valid, rsp_error, rsp_rdata);
      end
      ack_rsp();
   endtask

   task automatic test_backpressure();
      int hi, bad;
      logic st;
      bad = 0;
      run_cmd(1'b0, 30'h5, 4'hF, 32'h0, 0, 32'hCAFE_F00D, hi, st);
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D ||
             rsp_write !== 1'b0 || cmd_ready !== 1'b0)
            bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL bp_hold: unstable cycles=%0d required 0", bad);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
          rsp_rdata !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL bp_accept: v=%b rdy=%b d=%h required 0 1 cafef00d",
                  rsp_valid, cmd_ready, rsp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int hi, seen;
      logic st;
      seen = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 30'h77;
      cmd_be    = 4'hF;
      av_wait   = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (av_read !== 1'b1) begin
         n_err++;
         $display("FAIL rm_pre_strobe: got %b required 1", av_read);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (av_read !== 1'b0 || cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rm_async_drop: rd=%b rdy=%b required 0 0",
                  av_read, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      av_wait = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rsp_valid !== 1'b0 || av_read !== 1'b0) seen++;
         @(negedge clk);
      end
      av_wait = 1'b1;
      n_cmp++;
      if (seen !== 0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rm_no_rsp: stray=%0d rdy=%b required 0 1",
                  seen, cmd_ready);
      end
      run_cmd(1'b1, 30'h9, 4'h5, 32'h0BAD_CAFE, 2, 32'h0, hi, st);
      n_cmp++;
      if (hi !== 3 || st !== 1'b1 || rsp_valid !== 1'b1 ||
          rsp_write !== 1'b1 || rsp_error !== 1'b0) begin
         n_err++;
         $display("FAIL rm_after: hi=%0d st=%b v=%b w=%b e=%b required 3 1 1 1 0",
                  hi, st, rsp_valid, rsp_write, rsp_error);
      end
      ack_rsp();
   endtask

   initial begin
      test_reset();
      test_write_stall();
      test_read_stall();
      test_back_to_back();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
